// File: rtl/gcd_processor.sv
// 8-bit accumulator CPU running a built-in GCD program out of a 32x8 unified memory.
// Each instruction takes 3 cycles; INPUT stalls until Enter, and cheat freezes all state.
module gcd_processor (
    input  logic       clock,
    input  logic       reset,
    input  logic       cheat,
    input  logic       Enter,
    input  logic [7:0] Minput,
    output logic [7:0] Moutput,
    output logic       Halt,
    output logic [3:0] DisplayState,
    output logic [2:0] IR75
);

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  mem_q [32];
    logic        mem_we;
    logic [4:0]  addr;
    logic [7:0]  operand;

    assign addr    = ir_q[4:0];
    assign operand = mem_q[addr];

    // Boot image: X->M[30], Y->M[31], subtract the smaller from the larger until equal.
    function automatic logic [7:0] boot_word(input logic [4:0] a);
        case (a)
            5'd0:    boot_word = 8'h80;
            5'd1:    boot_word = 8'h3E;
            5'd2:    boot_word = 8'h80;
            5'd3:    boot_word = 8'h3F;
            5'd4:    boot_word = 8'h1E;
            5'd5:    boot_word = 8'h7F;
            5'd6:    boot_word = 8'hAE;
            5'd7:    boot_word = 8'hCC;
            5'd8:    boot_word = 8'h1F;
            5'd9:    boot_word = 8'h7E;
            5'd10:   boot_word = 8'h3F;
            5'd11:   boot_word = 8'hC4;
            5'd12:   boot_word = 8'h3E;
            5'd13:   boot_word = 8'hC4;
            5'd14:   boot_word = 8'h1E;
            5'd15:   boot_word = 8'hE0;
            default: boot_word = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_START;
        end else if (!cheat) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = state_t'({1'b1, ir_q[7:5]});
            S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS:
                      state_d = S_FETCH;
            S_INPUT:  state_d = Enter ? S_FETCH : S_INPUT;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_START;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        a_d    = a_q;
        mem_we = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d = mem_q[pc_q];
                pc_d = pc_q + 5'd1;
            end
            S_LOAD:  a_d    = operand;
            S_STORE: mem_we = 1'b1;
            S_ADD:   a_d    = a_q + operand;
            S_SUB:   a_d    = a_q - operand;
            S_INPUT: if (Enter) a_d = Minput;
            S_JZ:    if (a_q == 8'd0) pc_d = addr;
            S_JPOS:  if (!a_q[7] && a_q != 8'd0) pc_d = addr;
            default: ;
        endcase
    end

    assign Moutput      = a_q;
    assign Halt         = (state_q == S_HALT);
    assign DisplayState = state_q;
    assign IR75         = ir_q[7:5];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= 5'd0;
            ir_q <= 8'd0;
            a_q  <= 8'd0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= boot_word(5'(i));
            end
        end else if (!cheat) begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            a_q  <= a_d;
            if (mem_we) begin
                mem_q[addr] <= a_q;
            end
        end
    end

endmodule

// File: tb/tb_gcd_processor.sv
// Directed and random scenarios for the GCD accumulator CPU.
module tb_gcd_processor;

    logic       clock = 1'b0;
    logic       reset;
    logic       cheat;
    logic       Enter;
    logic [7:0] Minput;
    logic [7:0] Moutput;
    logic       Halt;
    logic [3:0] DisplayState;
    logic [2:0] IR75;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_processor dut (
        .clock        (clock),
        .reset        (reset),
        .cheat        (cheat),
        .Enter        (Enter),
        .Minput       (Minput),
        .Moutput      (Moutput),
        .Halt         (Halt),
        .DisplayState (DisplayState),
        .IR75         (IR75)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        cheat  = 1'b0;
        Enter  = 1'b0;
        Minput = 8'd0;
        tick(2);
        reset  = 1'b1;
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic enter_value(input logic [7:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (DisplayState == 4'd12) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            Minput = v;
            Enter  = 1'b1;
            tick();
            Enter  = 1'b0;
        end
    endtask

    task automatic wait_halt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            if (Halt) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_st [6] = '{4'd1, 4'd2, 4'd12, 4'd12, 4'd12, 4'd12};
        logic [2:0] exp_ir [6] = '{3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        reset = 1'b0; cheat = 1'b0; Enter = 1'b0; Minput = 8'd0;
        #1;
        n_checks++;
        if ({DisplayState, IR75, Halt, Moutput} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d ir75=%0d halt=%0b out=%0d, need all 0",
                     DisplayState, IR75, Halt, Moutput);
        end
        tick(2);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({DisplayState, IR75, Halt, Moutput} !== {exp_st[i], exp_ir[i], 1'b0, 8'd0}) begin
                n_fail++;
                $display("FAIL boot_seq[%0d]: state=%0d ir75=%0d halt=%0b out=%0d, need state=%0d ir75=%0d halt=0 out=0",
                         i, DisplayState, IR75, Halt, Moutput, exp_st[i], exp_ir[i]);
            end
        end
    endtask

    task automatic test_gcd_fixed(input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp);
        bit ok;
        do_reset();
        tick(4);
        n_checks++;
        if (DisplayState !== 4'd12) begin
            n_fail++;
            $display("FAIL first_input_state(%0d,%0d): state=%0d, need 12", x, y, DisplayState);
        end
        Minput = x; Enter = 1'b1; tick(); Enter = 1'b0;
        tick(7);
        n_checks++;
        if (DisplayState !== 4'd12) begin
            n_fail++;
            $display("FAIL second_input_state(%0d,%0d): state=%0d, need 12", x, y, DisplayState);
        end
        Minput = y; Enter = 1'b1; tick(); Enter = 1'b0;
        wait_halt(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL halt_timeout(%0d,%0d): halt=%0b, need 1", x, y, Halt);
        end
        n_checks++;
        if (Moutput !== exp) begin
            n_fail++;
            $display("FAIL gcd(%0d,%0d): out=%0d, need %0d", x, y, Moutput, exp);
        end
        n_checks++;
        if ({Halt, DisplayState, IR75} !== {1'b1, 4'hF, 3'b111}) begin
            n_fail++;
            $display("FAIL halt_outputs(%0d,%0d): halt=%0b state=%0d ir75=%0d, need 1/15/7",
                     x, y, Halt, DisplayState, IR75);
        end
        Minput = 8'hAA; Enter = 1'b1; tick(3); Enter = 1'b0;
        n_checks++;
        if ({Halt, Moutput} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL halt_hold(%0d,%0d): halt=%0b out=%0d, need 1/%0d", x, y, Halt, Moutput, exp);
        end
    endtask

    task automatic test_early_enter();
        bit ok1, ok2, ok3;
        do_reset();
        tick(2);
        Minput = 8'd50; Enter = 1'b1; tick(); Enter = 1'b0;
        n_checks++;
        if ({DisplayState, Moutput} !== {4'd12, 8'd0}) begin
            n_fail++;
            $display("FAIL early_enter_ignored: state=%0d out=%0d, need 12/0", DisplayState, Moutput);
        end
        enter_value(8'd9, ok1);
        enter_value(8'd6, ok2);
        wait_halt(ok3);
        n_checks++;
        if (!(ok1 && ok2 && ok3) || Moutput !== 8'd3) begin
            n_fail++;
            $display("FAIL early_enter_gcd: out=%0d halt=%0b, need 3/1", Moutput, Halt);
        end
    endtask

    task automatic test_reset_after_halt();
        bit ok1, ok2, ok3;
        n_checks++;
        if (Halt !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_halt: halt=%0b, need 1", Halt);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({Halt, DisplayState, Moutput} !== {1'b0, 4'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL async_reset: halt=%0b state=%0d out=%0d, need 0/0/0", Halt, DisplayState, Moutput);
        end
        tick();
        reset = 1'b1;
        enter_value(8'd100, ok1);
        enter_value(8'd75, ok2);
        wait_halt(ok3);
        n_checks++;
        if (!(ok1 && ok2 && ok3) || Moutput !== 8'd25) begin
            n_fail++;
            $display("FAIL rerun_gcd(100,75): out=%0d halt=%0b, need 25/1", Moutput, Halt);
        end
    endtask

    task automatic test_cheat();
        bit ok1, ok2, ok3;
        logic [14:0] snap;
        do_reset();
        enter_value(8'd100, ok1);
        enter_value(8'd75, ok2);
        tick(20);
        cheat = 1'b1;
        snap  = {DisplayState, IR75, Moutput};
        n_checks++;
        if (Halt !== 1'b0) begin
            n_fail++;
            $display("FAIL cheat_precondition: halt=%0b, need 0", Halt);
        end
        for (int i = 0; i < 10; i++) begin
            Enter  = i[0];
            Minput = 8'(i * 17);
            tick();
            n_checks++;
            if ({DisplayState, IR75, Moutput} !== snap) begin
                n_fail++;
                $display("FAIL cheat_freeze[%0d]: {state,ir75,out}=%h, need %h",
                         i, {DisplayState, IR75, Moutput}, snap);
            end
        end
        cheat = 1'b0;
        Enter = 1'b0;
        wait_halt(ok3);
        n_checks++;
        if (!(ok1 && ok2 && ok3) || Moutput !== 8'd25) begin
            n_fail++;
            $display("FAIL cheat_gcd(100,75): out=%0d halt=%0b, need 25/1", Moutput, Halt);
        end
    endtask

    task automatic test_mid_reset();
        bit ok1, ok2, ok3, ok4;
        do_reset();
        enter_value(8'd96, ok1);
        enter_value(8'd64, ok2);
        tick(15);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({DisplayState, Moutput} !== {4'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: state=%0d out=%0d, need 0/0", DisplayState, Moutput);
        end
        tick();
        reset = 1'b1;
        enter_value(8'd27, ok3);
        enter_value(8'd18, ok4);
        wait_halt(ok1);
        n_checks++;
        if (!(ok1 && ok2 && ok3 && ok4) || Moutput !== 8'd9) begin
            n_fail++;
            $display("FAIL mid_reset_gcd(27,18): out=%0d halt=%0b, need 9/1", Moutput, Halt);
        end
    endtask

    task automatic test_random();
        bit ok1, ok2, ok3;
        int x, y, g;
        for (int k = 0; k < 60; k++) begin
            x = $urandom_range(1, 127);
            y = $urandom_range(1, 127);
            g = ref_gcd(x, y);
            do_reset();
            enter_value(8'(x), ok1);
            enter_value(8'(y), ok2);
            wait_halt(ok3);
            n_checks++;
            if (!(ok1 && ok2 && ok3) || Moutput !== 8'(g)) begin
                n_fail++;
                $display("FAIL random_gcd(%0d,%0d): out=%0d halt=%0b, need %0d/1", x, y, Moutput, Halt, g);
            end
        end
    endtask

    initial begin
        test_reset();
        test_gcd_fixed(8'd12, 8'd18, 8'd6);
        test_gcd_fixed(8'd7, 8'd7, 8'd7);
        test_gcd_fixed(8'd1, 8'd127, 8'd1);
        test_gcd_fixed(8'd127, 8'd126, 8'd1);
        test_gcd_fixed(8'd96, 8'd64, 8'd32);
        test_early_enter();
        test_reset_after_halt();
        test_cheat();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
